// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int MEM_AW_DEF = 11;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Load-data extract/extend and sub-word store merge for the LSU.
// Purely combinational; fed from the latched request size/sign flag.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e              i_size,
    input  logic               i_unsigned,
    input  logic [DATA_W-1:0]  i_rd_q,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic [DATA_W-1:0]  o_load_data,
    output logic [DATA_W-1:0]  o_store_data
);

    // Pick the addressed lane of the read word and extend it per the sign flag.
    always_comb begin
        o_load_data = '0;
        unique case (i_size)
            SZ_B:    o_load_data = i_unsigned ? {24'h0, i_rd_q[7:0]}
                                              : {{24{i_rd_q[7]}}, i_rd_q[7:0]};
            SZ_H:    o_load_data = i_unsigned ? {16'h0, i_rd_q[15:0]}
                                              : {{16{i_rd_q[15]}}, i_rd_q[15:0]};
            SZ_W:    o_load_data = i_rd_q;
            default: o_load_data = '0;
        endcase
    end

    // Memory always writes four bytes, so sub-word stores keep the untouched bytes from rd_q.
    always_comb begin
        o_store_data = i_wdata;
        unique case (i_size)
            SZ_B:    o_store_data = {i_rd_q[31:8], i_wdata[7:0]};
            SZ_H:    o_store_data = {i_rd_q[31:16], i_wdata[15:0]};
            default: o_store_data = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit between the core MEM stage and a byte-addressed data memory.
// One request at a time; sub-word stores use read-modify-write.
// Optional build macro LSU_STATS_EN: enables saturating load/store/error counters;
// when undefined the stat ports read 0 and no counter flops exist.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// READ  | memory word at the latched offset is captured into rd_q
// WRITE | one-cycle write pulse of the merged word
// RESP  | response held until the core takes it
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_AW    = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [MEM_AW-1:0] o_mem_address,
    output logic              o_mem_wrt_en,
    output logic [31:0]       o_mem_write_data,
    input  logic [31:0]       i_mem_read_data,
    output logic [15:0]       o_stat_loads,
    output logic [15:0]       o_stat_stores,
    output logic [15:0]       o_stat_errs
);

    // Highest offset at which a full 4-byte window still fits in memory.
    localparam logic [31:0] LAST_OFF = 32'((2 ** MEM_AW) - 4);

    state_e              r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic                r_we;
    size_e               r_size;
    logic                r_unsigned;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rd_q;
    logic [MEM_AW-1:0]   r_mem_address;
    logic                r_mem_wrt_en;

    logic [31:0]         w_off32;
    size_e               w_req_size;
    logic                w_req_err;
    logic                w_accept;
    logic [31:0]         w_load_data;
    logic [31:0]         w_store_data;

    assign w_off32    = i_req_addr - BASE_ADDR;
    assign w_req_size = size_e'(i_req_size);
    assign w_req_err  = (i_req_addr < BASE_ADDR) || (w_off32 > LAST_OFF) || (w_req_size == SZ_BAD);
    assign w_accept   = i_req_valid && r_req_ready;

    lsu_align u_align (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_rd_q       (r_rd_q),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    // Request sequencing: latch on accept, then READ/WRITE as the request kind needs, then hold RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_we          <= 1'b0;
            r_size        <= SZ_B;
            r_unsigned    <= 1'b0;
            r_wdata       <= '0;
            r_rd_q        <= '0;
            r_mem_address <= '0;
            r_mem_wrt_en  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we        <= i_req_we;
                        r_size      <= w_req_size;
                        r_unsigned  <= i_req_unsigned;
                        r_wdata     <= i_req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            // Rejected requests never touch memory or its address.
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_mem_address <= w_off32[MEM_AW-1:0];
                            if (i_req_we && (w_req_size == SZ_W)) begin
                                r_mem_wrt_en <= 1'b1;
                                r_state      <= WRITE;
                            end else begin
                                r_state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    r_rd_q <= i_mem_read_data;
                    if (r_we) begin
                        r_mem_wrt_en <= 1'b1;
                        r_state      <= WRITE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                WRITE: begin
                    r_mem_wrt_en <= 1'b0;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready      = r_req_ready;
    assign o_rsp_valid      = r_rsp_valid;
    assign o_rsp_err        = r_rsp_err;
    assign o_mem_address    = r_mem_address;
    assign o_mem_wrt_en     = r_mem_wrt_en;
    // Read data only means something for a successful load; everything else reports 0.
    assign o_rsp_rdata      = (r_rsp_valid && !r_rsp_err && !r_we) ? w_load_data : '0;
    assign o_mem_write_data = (r_state == WRITE) ? w_store_data : '0;

`ifdef LSU_STATS_EN
    logic [15:0] r_stat_loads;
    logic [15:0] r_stat_stores;
    logic [15:0] r_stat_errs;

    // Count completed responses by kind; errors are counted only as errors.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_errs   <= '0;
        end else if (r_rsp_valid && i_rsp_ready) begin
            if (r_rsp_err) begin
                if (r_stat_errs != 16'hFFFF) r_stat_errs <= r_stat_errs + 16'd1;
            end else if (r_we) begin
                if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
            end else begin
                if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
            end
        end
    end

    assign o_stat_loads  = r_stat_loads;
    assign o_stat_stores = r_stat_stores;
    assign o_stat_errs   = r_stat_errs;
`else
    assign o_stat_loads  = '0;
    assign o_stat_stores = '0;
    assign o_stat_errs   = '0;
`endif

endmodule
